// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Optional checksum byte is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO  = 3'd0,
        HDR_HI  = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_e;

    localparam int unsigned HDR_BYTES = 2;
    localparam int unsigned CSUM_W    = 8;

    // Running XOR over payload bytes; the trailing frame byte must equal the final value.
    function automatic logic [CSUM_W-1:0] csum_step(input logic [CSUM_W-1:0] acc,
                                                    input logic [7:0]        data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
// master = stream source, slave = loader.
interface imem_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs little-endian bytes into 32-bit words; pulses o_word_valid for one
// cycle after the edge that accepted the fourth byte of a word.
module imem_loader_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_idx,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_idx;
    logic [23:0] r_part;
    logic [31:0] r_word;
    logic        r_word_valid;

    // Byte lane accumulation and word emission
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= 2'd0;
            r_part       <= 24'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_byte_valid) begin
                r_idx <= r_idx + 2'd1;
                case (r_idx)
                    2'd0:    r_part[7:0]   <= i_byte;
                    2'd1:    r_part[15:8]  <= i_byte;
                    2'd2:    r_part[23:16] <= i_byte;
                    2'd3: begin
                        r_word       <= {i_byte, r_part};
                        r_word_valid <= 1'b1;
                        r_part       <= 24'd0;
                    end
                    default: r_part <= 24'd0;
                endcase
            end
        end
    end

    assign o_idx        = r_idx;
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: header, payload words, optional checksum
// (IMEM_LOADER_CHECKSUM_EN). Holds the core in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_loader_if.slave      bus,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_rst_n,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_words_loaded
);

    localparam logic [31:0]   DEPTH = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    state_e            r_state;
    logic              r_in_ready;
    logic [7:0]        r_lo;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_word_idx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_done;
    logic              r_err;
    logic              r_cpu_rst_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] r_csum;
`endif

    logic        w_xfer;
    logic        w_pay_xfer;
    logic        w_word_end;
    logic        w_last;
    logic [15:0] w_n;
    logic [1:0]  w_idx;
    logic [31:0] w_word;
    logic        w_word_valid;

    assign w_xfer     = bus.in_valid & r_in_ready;
    assign w_pay_xfer = w_xfer & (r_state == PAYLOAD);
    assign w_word_end = w_pay_xfer & (w_idx == 2'd3);
    assign w_last     = w_word_end & ((r_word_idx + ONE) == r_count);
    assign w_n        = {bus.in_data, r_lo};

    imem_loader_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_byte_valid (w_pay_xfer),
        .i_byte       (bus.in_data),
        .o_idx        (w_idx),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // Frame FSM with addressing, status flags and core reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HDR_LO;
            r_in_ready  <= 1'b0;
            r_lo        <= 8'd0;
            r_count     <= '0;
            r_word_idx  <= '0;
            r_addr      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            case (r_state)
                HDR_LO: begin
                    r_in_ready <= 1'b1;
                    if (w_xfer) begin
                        r_lo    <= bus.in_data;
                        r_state <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (w_xfer) begin
                        if ({16'd0, w_n} > DEPTH) begin
                            r_state    <= ERR;
                            r_err      <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else if (w_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= CHECK;
`else
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_in_ready <= 1'b0;
`endif
                        end else begin
                            r_count <= (ADDR_W+1)'(w_n);
                            r_state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_pay_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= csum_step(r_csum, bus.in_data);
`endif
                        if (w_word_end) begin
                            r_addr     <= r_word_idx[ADDR_W-1:0];
                            r_word_idx <= r_word_idx + ONE;
                        end
                        if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= CHECK;
`else
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_in_ready <= 1'b0;
`endif
                        end
                    end
                end
                CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        if (bus.in_data == r_csum) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                    end
`else
                    r_state    <= ERR;
                    r_err      <= 1'b1;
                    r_in_ready <= 1'b0;
`endif
                end
                DONE: begin
                    r_in_ready  <= 1'b0;
                    r_cpu_rst_n <= 1'b1;
                end
                ERR: begin
                    r_in_ready  <= 1'b0;
                    r_cpu_rst_n <= 1'b0;
                end
                default: begin
                    r_state    <= ERR;
                    r_err      <= 1'b1;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign o_imem_we      = w_word_valid;
    assign o_imem_addr    = r_addr;
    assign o_imem_wdata   = w_word;
    assign o_cpu_rst_n    = r_cpu_rst_n;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_words_loaded = r_word_idx;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam int ADDR_W = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int DONE_LAG = 1;
`else
    localparam int DONE_LAG = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       o_imem_wdata;
    logic              o_cpu_rst_n;
    logic              o_done;
    logic              o_err;
    logic [ADDR_W:0]   o_words_loaded;

    imem_loader_if u_if ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (u_if),
        .o_imem_we      (o_imem_we),
        .o_imem_addr    (o_imem_addr),
        .o_imem_wdata   (o_imem_wdata),
        .o_cpu_rst_n    (o_cpu_rst_n),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_words_loaded (o_words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]        tx_q[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int                wl_q[$];
    int                wc_q[$];
    int                first_cpu  = -1;
    int                first_done = -1;
    bit                watch_ready = 1'b0;
    bit                ready_dropped = 1'b0;

    logic [31:0] exp3 [3] = '{32'h00500093, 32'h00300113, 32'h00000193};

    always @(posedge clk) cyc <= cyc + 1;

    // Record every instruction-memory write and first rise of done / cpu_rst_n
    always @(negedge clk) begin
        if (o_imem_we) begin
            wa_q.push_back(o_imem_addr);
            wd_q.push_back(o_imem_wdata);
            wl_q.push_back(int'(o_words_loaded));
            wc_q.push_back(cyc);
        end
        if (o_cpu_rst_n && first_cpu < 0) first_cpu = cyc;
        if (o_done && first_done < 0) first_done = cyc;
        if (watch_ready && !o_done && !u_if.in_ready) ready_dropped = 1'b1;
    end

    task automatic apply_reset();
        u_if.in_valid = 1'b0;
        u_if.in_data  = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        wa_q.delete(); wd_q.delete(); wl_q.delete(); wc_q.delete();
        first_cpu = -1; first_done = -1; ready_dropped = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_queue(input bit gaps);
        foreach (tx_q[k]) begin
            int t = 0;
            u_if.in_valid = 1'b1;
            u_if.in_data  = tx_q[k];
            while (!u_if.in_ready && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            n_checks++;
            if (t >= 20) begin
                n_fail++;
                $display("FAIL handshake byte %0d: in_ready got 0 expected 1", k);
                u_if.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (gaps) begin
                u_if.in_valid = 1'b0;
                u_if.in_data  = 8'hEE;
                @(posedge clk); #1;
            end
        end
        u_if.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        u_if.in_valid = 1'b1;
        u_if.in_data  = 8'h55;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({u_if.in_ready, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_rst_n, o_done, o_err, o_words_loaded} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b we=%b a=%0h d=%0h cpu=%b dn=%b er=%b wl=%0d expected all 0",
                     u_if.in_ready, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_rst_n, o_done, o_err, o_words_loaded);
        end
        u_if.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (u_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", u_if.in_ready);
        end
    endtask

    task automatic check_three_words(input string tag, input int spacing);
        n_checks++;
        if (wa_q.size() != 3) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d expected 3", tag, wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp3[i] || wl_q[i] != i + 1) begin
                    n_fail++;
                    $display("FAIL %s write%0d: got a=%0h d=%h wl=%0d expected a=%0h d=%h wl=%0d",
                             tag, i, wa_q[i], wd_q[i], wl_q[i], i, exp3[i], i + 1);
                end
            end
            n_checks++;
            if (wc_q[1] - wc_q[0] != spacing || wc_q[2] - wc_q[1] != spacing) begin
                n_fail++;
                $display("FAIL %s spacing: got %0d,%0d expected %0d", tag,
                         wc_q[1] - wc_q[0], wc_q[2] - wc_q[1], spacing);
            end
            n_checks++;
            if (first_done - wc_q[2] != DONE_LAG || first_cpu - wc_q[2] != DONE_LAG + 1) begin
                n_fail++;
                $display("FAIL %s release_timing: got done+%0d cpu+%0d expected done+%0d cpu+%0d",
                         tag, first_done - wc_q[2], first_cpu - wc_q[2], DONE_LAG, DONE_LAG + 1);
            end
        end
        n_checks++;
        if (o_words_loaded !== 9'd3 || o_done !== 1'b1 || o_err !== 1'b0 ||
            u_if.in_ready !== 1'b0 || o_cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL %s final_status: got wl=%0d dn=%b er=%b rdy=%b cpu=%b expected 3 1 0 0 1",
                     tag, o_words_loaded, o_done, o_err, u_if.in_ready, o_cpu_rst_n);
        end
    endtask

    task automatic load_frame3();
        tx_q = {8'h03, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                8'h13, 8'h01, 8'h30, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h73);  // 93^50^13^01^30^93^01
`endif
    endtask

    task automatic test_load3();
        apply_reset();
        load_frame3();
        send_queue(1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check_three_words("load3", 4);
    endtask

    task automatic test_valid_toggle();
        apply_reset();
        load_frame3();
        watch_ready = 1'b1;
        send_queue(1'b1);
        watch_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_three_words("toggle", 8);
        n_checks++;
        if (ready_dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_ready: got drop=%b expected 0", ready_dropped);
        end
    endtask

    task automatic test_oversize();
        apply_reset();
        tx_q = {8'h01, 8'h01};
        send_queue(1'b0);
        n_checks++;
        if (o_err !== 1'b1 || u_if.in_ready !== 1'b0 || o_done !== 1'b0 || o_cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL oversize_edge: got er=%b rdy=%b dn=%b cpu=%b expected 1 0 0 0",
                     o_err, u_if.in_ready, o_done, o_cpu_rst_n);
        end
        u_if.in_valid = 1'b1;
        u_if.in_data  = 8'h13;
        repeat (6) begin @(posedge clk); #1; end
        u_if.in_valid = 1'b0;
        n_checks++;
        if (wa_q.size() != 0 || o_cpu_rst_n !== 1'b0 || o_err !== 1'b1 || o_words_loaded !== 9'd0) begin
            n_fail++;
            $display("FAIL oversize_hold: got writes=%0d cpu=%b er=%b wl=%0d expected 0 0 1 0",
                     wa_q.size(), o_cpu_rst_n, o_err, o_words_loaded);
        end
        apply_reset();
        tx_q = {8'h00, 8'h01};
        send_queue(1'b0);
        n_checks++;
        if (o_err !== 1'b0 || u_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL max_depth_hdr: got er=%b rdy=%b expected 0 1", o_err, u_if.in_ready);
        end
    endtask

    task automatic test_zero_len();
        apply_reset();
        tx_q = {8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h00);
`endif
        send_queue(1'b0);
        n_checks++;
        if (o_done !== 1'b1 || o_err !== 1'b0 || o_cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_edge: got dn=%b er=%b cpu=%b expected 1 0 0", o_done, o_err, o_cpu_rst_n);
        end
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (o_cpu_rst_n !== 1'b1 || wa_q.size() != 0 || first_cpu != first_done + 1) begin
            n_fail++;
            $display("FAIL zero_len_release: got cpu=%b writes=%0d lag=%0d expected 1 0 1",
                     o_cpu_rst_n, wa_q.size(), first_cpu - first_done);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        apply_reset();
        tx_q = {8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h06};  // 13^05^10^00 = 06
        send_queue(1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (o_done !== 1'b1 || o_err !== 1'b0 || o_cpu_rst_n !== 1'b1 ||
            wd_q.size() != 1 || wd_q[0] !== 32'h00100513) begin
            n_fail++;
            $display("FAIL csum_good: got dn=%b er=%b cpu=%b writes=%0d expected 1 0 1 1",
                     o_done, o_err, o_cpu_rst_n, wd_q.size());
        end
        apply_reset();
        tx_q = {8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h47};
        send_queue(1'b0);
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (o_err !== 1'b1 || o_done !== 1'b0 || o_cpu_rst_n !== 1'b0 || u_if.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL csum_bad: got er=%b dn=%b cpu=%b rdy=%b expected 1 0 0 0",
                     o_err, o_done, o_cpu_rst_n, u_if.in_ready);
        end
    endtask
`endif

    task automatic test_mid_reset();
        apply_reset();
        tx_q = {8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        send_queue(1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (wd_q.size() != 1 || wd_q[0] !== 32'hDDCCBBAA || o_words_loaded !== 9'd1) begin
            n_fail++;
            $display("FAIL midrst_partial: got writes=%0d wl=%0d expected 1 1", wd_q.size(), o_words_loaded);
        end
        apply_reset();
        n_checks++;
        if (o_words_loaded !== 9'd0 || o_imem_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_cleared: got wl=%0d a=%0h expected 0 0", o_words_loaded, o_imem_addr);
        end
        tx_q = {8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef IMEM_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h08);  // 01^02^...^08
`endif
        send_queue(1'b0);
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (wa_q.size() != 2) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d expected 2", wa_q.size());
        end else begin
            n_checks++;
            if (wa_q[0] !== 8'd0 || wd_q[0] !== 32'h04030201 || wa_q[1] !== 8'd1 || wd_q[1] !== 32'h08070605) begin
                n_fail++;
                $display("FAIL midrst_data: got %0h:%h %0h:%h expected 0:04030201 1:08070605",
                         wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
            end
        end
        n_checks++;
        if (o_words_loaded !== 9'd2 || o_done !== 1'b1 || o_cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_final: got wl=%0d dn=%b cpu=%b expected 2 1 1",
                     o_words_loaded, o_done, o_cpu_rst_n);
        end
    endtask

    initial begin
        u_if.in_valid = 1'b0;
        u_if.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        test_reset();
        test_load3();
        test_valid_toggle();
        test_oversize();
        test_zero_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
